// File: rtl/fa_pkg.sv
// Shared constants and helpers for the chunked, carry-pipelined adder.
package fa_pkg;

   localparam int FA_WIDTH  = 16;
   localparam int FA_STAGES = 4;

   function automatic int fa_cw(input int width, input int stages);
      return width / stages;
   endfunction

endpackage

// File: rtl/fa_stage.sv
// One pipeline slice: adds operand chunk IDX with the incoming registered carry and
// carries the not-yet-added operand chunks and the already-finished sum chunks with it.
module fa_stage
   import fa_pkg::*;
#(
   parameter int WIDTH = FA_WIDTH,
   parameter int CW    = fa_cw(FA_WIDTH, FA_STAGES),
   parameter int IDX   = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_en,
   input  logic             i_vld,
   input  logic             i_c,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic [WIDTH-1:0] i_s,
   output logic             o_vld,
   output logic             o_c,
   output logic [WIDTH-1:0] o_a,
   output logic [WIDTH-1:0] o_b,
   output logic [WIDTH-1:0] o_s
);

   logic [CW:0]      w_add;
   logic [WIDTH-1:0] w_s;

   logic             r_vld;
   logic             r_c;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_s;

   always_comb begin
      w_add = {1'b0, i_a[IDX*CW +: CW]} + {1'b0, i_b[IDX*CW +: CW]} + {{CW{1'b0}}, i_c};
      w_s   = i_s;
      w_s[IDX*CW +: CW] = w_add[CW-1:0];
   end

   // Data is cleared too so that s/co/ov read as zero straight out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld <= 1'b0;
         r_c   <= 1'b0;
         r_a   <= '0;
         r_b   <= '0;
         r_s   <= '0;
      end else if (i_en) begin
         r_vld <= i_vld;
         r_c   <= w_add[CW];
         r_a   <= i_a;
         r_b   <= i_b;
         r_s   <= w_s;
      end
   end

   assign o_vld = r_vld;
   assign o_c   = r_c;
   assign o_a   = r_a;
   assign o_b   = r_b;
   assign o_s   = r_s;

endmodule

// File: rtl/fa_pipe.sv
// Pipelined add/subtract: WIDTH bits split into STAGES chunks, one chunk per stage,
// with a single advance enable giving valid/ready flow control on both sides.
module fa_pipe
   import fa_pkg::*;
#(
   parameter int WIDTH  = FA_WIDTH,
   parameter int STAGES = FA_STAGES
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             co,
   output logic             ov
);

   localparam int CW = fa_cw(WIDTH, STAGES);

   logic             w_en;
   logic             w_vld [0:STAGES];
   logic             w_c   [0:STAGES];
   logic [WIDTH-1:0] w_a   [0:STAGES];
   logic [WIDTH-1:0] w_b   [0:STAGES];
   logic [WIDTH-1:0] w_s   [0:STAGES];

   assign w_en     = ~out_valid | out_ready;
   assign in_ready = w_en;

   // Subtraction is a + ~b + 1, so b is inverted once here and carried inverted.
   assign w_vld[0] = in_valid;
   assign w_c[0]   = sub ? 1'b1 : ci;
   assign w_a[0]   = a;
   assign w_b[0]   = sub ? ~b : b;
   assign w_s[0]   = '0;

   generate
      for (genvar k = 0; k < STAGES; k++) begin : g_stage
         fa_stage #(
            .WIDTH (WIDTH),
            .CW    (CW),
            .IDX   (k)
         ) u_stage (
            .clk   (clk),
            .rst_n (rst_n),
            .i_en  (w_en),
            .i_vld (w_vld[k]),
            .i_c   (w_c[k]),
            .i_a   (w_a[k]),
            .i_b   (w_b[k]),
            .i_s   (w_s[k]),
            .o_vld (w_vld[k+1]),
            .o_c   (w_c[k+1]),
            .o_a   (w_a[k+1]),
            .o_b   (w_b[k+1]),
            .o_s   (w_s[k+1])
         );
      end
   endgenerate

   assign out_valid = w_vld[STAGES];
   assign s         = w_s[STAGES];
   assign co        = w_c[STAGES];
   assign ov        = (w_a[STAGES][WIDTH-1] == w_b[STAGES][WIDTH-1]) &&
                      (w_s[STAGES][WIDTH-1] != w_a[STAGES][WIDTH-1]);

endmodule

// File: tb/tb_fa_pipe.sv
// Bench for fa_pipe in three shapes (16x4, 4x1, 32x8) against an arithmetic model.
module tb_fa_pipe;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic        iv16, ir16, ci16, sub16, ovld16, ordy16, co16, of16;
   logic [15:0] a16, b16, s16;
   logic        iv4, ir4, ci4, sub4, ovld4, ordy4, co4, of4;
   logic [3:0]  a4, b4, s4;
   logic        iv32, ir32, ci32, sub32, ovld32, ordy32, co32, of32;
   logic [31:0] a32, b32, s32;

   fa_pipe #(.WIDTH(16), .STAGES(4)) u_p16 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
      .ci(ci16), .sub(sub16), .out_valid(ovld16), .out_ready(ordy16), .s(s16), .co(co16), .ov(of16));

   fa_pipe #(.WIDTH(4), .STAGES(1)) u_p4 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
      .ci(ci4), .sub(sub4), .out_valid(ovld4), .out_ready(ordy4), .s(s4), .co(co4), .ov(of4));

   fa_pipe #(.WIDTH(32), .STAGES(8)) u_p32 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
      .ci(ci32), .sub(sub32), .out_valid(ovld32), .out_ready(ordy32), .s(s32), .co(co32), .ov(of32));

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Returns {ov, co, s}: s/co from modular arithmetic, ov from signed range.
   function automatic logic [33:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                         input logic ci, input logic sub);
      longint unsigned mask, ua, ub, full;
      longint          lim, sa, sb, res;
      logic [31:0]     sv;
      logic            cov, ovf;
      mask = (64'd1 << w) - 64'd1;
      ua   = {32'd0, a} & mask;
      ub   = {32'd0, b} & mask;
      full = ua + (sub ? (~ub & mask) : ub) + (sub ? 64'd1 : {63'd0, ci});
      sv   = full[31:0] & mask[31:0];
      cov  = full[w];
      lim  = longint'(64'd1 << (w - 1));
      sa   = (longint'(ua) >= lim) ? longint'(ua) - 2 * lim : longint'(ua);
      sb   = (longint'(ub) >= lim) ? longint'(ub) - 2 * lim : longint'(ub);
      res  = sub ? (sa - sb) : (sa + sb + longint'({63'd0, ci}));
      ovf  = (res >= lim) || (res < -lim);
      return {ovf, cov, sv};
   endfunction

   task automatic run16(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic ci, input logic sub);
      logic [33:0] e;
      e      = model(16, {16'd0, a}, {16'd0, b}, ci, sub);
      a16    = a;
      b16    = b;
      ci16   = ci;
      sub16  = sub;
      iv16   = 1'b1;
      ordy16 = 1'b1;
      #1;
      check({tag, "_inrdy"}, 64'(ir16), 64'd1);
      tick();
      iv16 = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         check($sformatf("%s_vld_c%0d", tag, k), 64'(ovld16), 64'(k == 4));
         if (k < 4) tick();
      end
      check({tag, "_res"}, 64'({of16, co16, s16}), 64'({e[33:32], e[15:0]}));
      tick();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [31:0] r1, r2;
      logic [33:0] e;
      logic [33:0] q[$];
      logic [34:0] held;
      logic        hold;
      logic        rdy0;
      int          nout, idx;

      {iv16, ci16, sub16, ordy16, a16, b16} = '0;
      {iv4, ci4, sub4, ordy4, a4, b4}       = '0;
      {iv32, ci32, sub32, ordy32, a32, b32} = '0;

      // reset behaviour
      #1 rst_n = 1'b0;
      #1;
      check("rst_ovld", 64'(ovld16), 64'd0);
      check("rst_result", 64'({of16, co16, s16}), 64'd0);
      check("rst_inrdy", 64'(ir16), 64'd1);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      check("post_rst_inrdy", 64'(ir16), 64'd1);

      // directed vectors, then a handful of random ones, each with latency check
      run16("wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0);
      run16("sovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0);
      run16("sub57", 16'h0005, 16'h0007, 1'b0, 1'b1);
      run16("sub_neg_ovf", 16'h8000, 16'h0001, 1'b1, 1'b1);
      for (int i = 0; i < 6; i++) begin
         r1 = $urandom;
         r2 = $urandom;
         run16("rnd16", r1[15:0], r1[31:16], r2[0], r2[1]);
      end

      // 8 back-to-back transactions with a 3-cycle consumer stall
      q.delete();
      idx  = 0;
      nout = 0;
      hold = 1'b0;
      held = '0;
      for (int cyc = 0; cyc < 30; cyc++) begin
         ordy16 = !(cyc >= 6 && cyc <= 8);
         if (idx < 8) begin
            r1 = $urandom;
            r2 = $urandom;
            a16 = r1[15:0]; b16 = r1[31:16]; ci16 = r2[0]; sub16 = r2[1]; iv16 = 1'b1;
         end else begin
            iv16 = 1'b0;
         end
         #1;
         if (cyc < 16) check($sformatf("b2b_inrdy_c%0d", cyc), 64'(ir16), 64'(!(cyc >= 6 && cyc <= 8)));
         if (hold) check("b2b_hold", 64'({ovld16, of16, co16, s16}), 64'(held));
         if (iv16 && ir16) begin
            q.push_back(model(16, {16'd0, a16}, {16'd0, b16}, ci16, sub16));
            idx++;
         end
         if (ovld16 && ordy16) begin
            nout++;
            if (q.size() == 0) check("b2b_extra", 64'd1, 64'd0);
            else begin
               e = q.pop_front();
               check("b2b_res", 64'({of16, co16, s16}), 64'({e[33:32], e[15:0]}));
            end
         end
         hold = ovld16 && !ordy16;
         held = {16'd0, ovld16, of16, co16, s16};
         tick();
      end
      check("b2b_count", 64'(nout), 64'd8);

      // reset with three transactions in flight
      ordy16 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         r1 = $urandom;
         a16 = r1[15:0]; b16 = r1[31:16]; ci16 = 1'b0; sub16 = 1'b0; iv16 = 1'b1;
         tick();
      end
      iv16 = 1'b0;
      tick();
      check("mid_ovld_pre", 64'(ovld16), 64'd1);
      rst_n = 1'b0;
      #1;
      check("mid_ovld_rst", 64'(ovld16), 64'd0);
      check("mid_result_rst", 64'({of16, co16, s16}), 64'd0);
      check("mid_inrdy_rst", 64'(ir16), 64'd1);
      tick();
      rst_n  = 1'b1;
      ordy16 = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         check("mid_no_ghost", 64'(ovld16), 64'd0);
      end
      run16("post_mid_rst", 16'h1234, 16'h4321, 1'b1, 1'b0);

      // WIDTH=4, STAGES=1: exhaustive add (with ci) and sub (ci randomised, ignored)
      ordy4 = 1'b1;
      for (int sb = 0; sb < 2; sb++) begin
         for (int x = 0; x < 256; x++) begin
            for (int c = 0; c < 2; c++) begin
               if (sb == 1 && c == 1) continue;
               r1   = $urandom;
               a4   = x[7:4];
               b4   = x[3:0];
               sub4 = sb[0];
               ci4  = sb[0] ? r1[0] : c[0];
               iv4  = 1'b1;
               e    = model(4, {28'd0, a4}, {28'd0, b4}, ci4, sub4);
               tick();
               check($sformatf("x4_a%0h_b%0h_ci%0d_sub%0d", a4, b4, ci4, sub4),
                     64'({ovld4, of4, co4, s4}), 64'({1'b1, e[33:32], e[3:0]}));
            end
         end
      end
      iv4 = 1'b0;
      tick();
      check("x4_idle", 64'(ovld4), 64'd0);

      // WIDTH=32, STAGES=8: random valid/ready with scoreboard
      q.delete();
      hold = 1'b0;
      held = '0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         iv32   = ($urandom_range(0, 9) < 7);
         ordy32 = ($urandom_range(0, 9) < 6);
         r1 = $urandom;
         a32 = $urandom;
         b32 = $urandom;
         ci32 = r1[0];
         sub32 = r1[1];
         #1;
         check("r32_inrdy", 64'(ir32), 64'(!ovld32 || ordy32));
         rdy0 = ir32;
         iv32 = !iv32;
         #1;
         check("r32_inrdy_indep", 64'(ir32), 64'(rdy0));
         iv32 = !iv32;
         #1;
         if (hold) check("r32_hold", 64'({ovld32, of32, co32, s32}), 64'(held));
         if (iv32 && ir32) q.push_back(model(32, a32, b32, ci32, sub32));
         if (ovld32 && ordy32) begin
            if (q.size() == 0) check("r32_extra", 64'd1, 64'd0);
            else begin
               e = q.pop_front();
               check("r32_res", 64'({of32, co32, s32}), 64'(e));
            end
         end
         hold = ovld32 && !ordy32;
         held = {ovld32, of32, co32, s32};
         tick();
      end
      iv32   = 1'b0;
      ordy32 = 1'b1;
      for (int i = 0; i < 40 && q.size() > 0; i++) begin
         if (ovld32) begin
            e = q.pop_front();
            check("r32_drain_res", 64'({of32, co32, s32}), 64'(e));
         end
         tick();
      end
      check("r32_drain_left", 64'(q.size()), 64'd0);
      check("r32_drain_idle", 64'(ovld32), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
